// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // Number of byte lanes covering a register of the given width.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  localparam int BE_W = be_width(DEF_DATA_W);

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: register select, optional write forwarding, zero register.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   mem [2**ADDR_W],
  input  logic                wr_en0,
  input  logic [ADDR_W-1:0]   wr_addr0,
  input  logic [DATA_W-1:0]   wr_data0,
  input  logic [DATA_W/8-1:0] wr_be0,
  input  logic                wr_en1,
  input  logic [ADDR_W-1:0]   wr_addr1,
  input  logic [DATA_W-1:0]   wr_data1,
  input  logic [DATA_W/8-1:0] wr_be1,
  output logic [DATA_W-1:0]   data
);

  localparam int NB = be_width(DATA_W);

  // Port 1 wins per byte over port 0; unselected bytes keep the stored value.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old,
    input logic              hit0,
    input logic [DATA_W-1:0] d0,
    input logic [NB-1:0]     be0,
    input logic              hit1,
    input logic [DATA_W-1:0] d1,
    input logic [NB-1:0]     be1
  );
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) begin
      if (hit1 && be1[b])      r[8*b +: 8] = d1[8*b +: 8];
      else if (hit0 && be0[b]) r[8*b +: 8] = d0[8*b +: 8];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] merged;
  logic              hit0;
  logic              hit1;

  always_comb begin
    stored = mem[addr];
    hit0   = wr_en0 && (wr_addr0 == addr);
    hit1   = wr_en1 && (wr_addr1 == addr);
    merged = merge_bytes(stored, hit0, wr_data0, wr_be0, hit1, wr_data1, wr_be1);
    data   = (BYPASS != 0) ? merged : stored;
    if ((ZERO_REG != 0) && (addr == '0)) data = '0;
    // Forwarding must not leak write data while the array is held in reset.
    if (!reset) data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two byte-masked write ports, NUM_RD combinational read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
  output logic [NUM_RD*DATA_W-1:0]   rdData,
  input  logic                       wrEn0,
  input  logic                       wrEn1,
  input  logic [ADDR_W-1:0]          wrAddr0,
  input  logic [ADDR_W-1:0]          wrAddr1,
  input  logic [DATA_W-1:0]          wrData0,
  input  logic [DATA_W-1:0]          wrData1,
  input  logic [DATA_W/8-1:0]        wrBe0,
  input  logic [DATA_W/8-1:0]        wrBe1
);

  localparam int NB    = be_width(DATA_W);
  localparam int DEPTH = 2**ADDR_W;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old,
    input logic              hit0,
    input logic [DATA_W-1:0] d0,
    input logic [NB-1:0]     be0,
    input logic              hit1,
    input logic [DATA_W-1:0] d1,
    input logic [NB-1:0]     be1
  );
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) begin
      if (hit1 && be1[b])      r[8*b +: 8] = d1[8*b +: 8];
      else if (hit0 && be0[b]) r[8*b +: 8] = d0[8*b +: 8];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // Register 0 is never written when hardwired, so it stays at its reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!((ZERO_REG != 0) && (i == 0))) begin
          mem[i] <= merge_bytes(mem[i],
                                wrEn0 && (wrAddr0 == ADDR_W'(i)), wrData0, wrBe0,
                                wrEn1 && (wrAddr1 == ADDR_W'(i)), wrData1, wrBe1);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rdport (
      .reset   (reset),
      .addr    (rdAddr[k*ADDR_W +: ADDR_W]),
      .mem     (mem),
      .wr_en0  (wrEn0),
      .wr_addr0(wrAddr0),
      .wr_data0(wrData0),
      .wr_be0  (wrBe0),
      .wr_en1  (wrEn1),
      .wr_addr1(wrAddr1),
      .wr_data1(wrData1),
      .wr_be1  (wrBe1),
      .data    (rdData[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a forwarding build and a non-forwarding build share stimulus.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   rd_addr;
  logic [127:0] rd_b;
  logic [127:0] rd_n;
  logic         wr_en0, wr_en1;
  logic [4:0]   wr_addr0, wr_addr1;
  logic [63:0]  wr_data0, wr_data1;
  logic [7:0]   wr_be0, wr_be1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_dut_b (
    .clk(clk), .reset(reset), .rdAddr(rd_addr), .rdData(rd_b),
    .wrEn0(wr_en0), .wrEn1(wr_en1), .wrAddr0(wr_addr0), .wrAddr1(wr_addr1),
    .wrData0(wr_data0), .wrData1(wr_data1), .wrBe0(wr_be0), .wrBe1(wr_be1)
  );

  regfile_mp #(.BYPASS(0)) u_dut_n (
    .clk(clk), .reset(reset), .rdAddr(rd_addr), .rdData(rd_n),
    .wrEn0(wr_en0), .wrEn1(wr_en1), .wrAddr0(wr_addr0), .wrAddr1(wr_addr1),
    .wrData0(wr_data0), .wrData1(wr_data1), .wrBe0(wr_be0), .wrBe1(wr_be1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    wr_be0 = 8'h00; wr_be1 = 8'h00;
    wr_data0 = '0;  wr_data1 = '0;
    wr_addr0 = '0;  wr_addr1 = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    rd_addr = {5'd0, 5'd5};
    // Write attempted while reset is low: forwarding suppressed, edge at 5 ns lost.
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 64'hDEADBEEFDEADBEEF; wr_be0 = 8'hFF;
    #2;
    chk("rst_byp_b", rd_b[63:0], 64'h0);
    chk("rst_byp_n", rd_n[63:0], 64'h0);
    #10;
    reset = 1'b1;
    idle();
    #1;
    chk("rst_lost_wr", rd_b[63:0], 64'h0);

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk("rst_p0", rd_b[63:0], 64'h0);
      chk("rst_p1", rd_b[127:64], 64'h0);
    end

    // Full write then lower-half byte-masked write to reg 1.
    tick();
    wr_en0 = 1'b1; wr_addr0 = 5'd1; wr_data0 = 64'hAAAAAAAAAAAAAAAA; wr_be0 = 8'hFF;
    tick();
    idle();
    rd_addr = {5'd1, 5'd1};
    #1;
    chk("wr_full", rd_b[63:0], 64'hAAAAAAAAAAAAAAAA);
    wr_en0 = 1'b1; wr_addr0 = 5'd1; wr_data0 = 64'h5555555555555555; wr_be0 = 8'h0F;
    #1;
    chk("be_fwd_b", rd_b[63:0], 64'hAAAAAAAA55555555);
    chk("be_fwd_n", rd_n[63:0], 64'hAAAAAAAAAAAAAAAA);
    tick();
    idle();
    #1;
    chk("wr_be", rd_b[63:0], 64'hAAAAAAAA55555555);
    chk("wr_be_n", rd_n[127:64], 64'hAAAAAAAA55555555);

    // Enable with no byte lanes selected.
    wr_en0 = 1'b1; wr_addr0 = 5'd1; wr_data0 = 64'h0; wr_be0 = 8'h00;
    tick();
    idle();
    #1;
    chk("be_zero", rd_b[63:0], 64'hAAAAAAAA55555555);

    // Both ports to reg 2: port 1 owns the upper bytes.
    wr_en0 = 1'b1; wr_addr0 = 5'd2; wr_data0 = 64'h1111111111111111; wr_be0 = 8'hFF;
    wr_en1 = 1'b1; wr_addr1 = 5'd2; wr_data1 = 64'h2222222222222222; wr_be1 = 8'hF0;
    rd_addr = {5'd2, 5'd2};
    #1;
    chk("dual_fwd", rd_b[127:64], 64'h2222222211111111);
    tick();
    idle();
    #1;
    chk("dual_p0", rd_b[63:0], 64'h2222222211111111);
    chk("dual_p1", rd_b[127:64], 64'h2222222211111111);
    chk("dual_n", rd_n[63:0], 64'h2222222211111111);

    // Hardwired zero register.
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 64'hFFFFFFFFFFFFFFFF; wr_be0 = 8'hFF;
    rd_addr = {5'd0, 5'd0};
    #1;
    chk("zero_same_b", rd_b[63:0], 64'h0);
    chk("zero_same_n", rd_n[127:64], 64'h0);
    tick();
    idle();
    #1;
    chk("zero_next", rd_b[63:0], 64'h0);

    // Forwarding vs non-forwarding on reg 3 via write port 1.
    wr_en1 = 1'b1; wr_addr1 = 5'd3; wr_data1 = 64'hCCCCCCCCCCCCCCCC; wr_be1 = 8'hFF;
    rd_addr = {5'd3, 5'd2};
    #1;
    chk("byp_same_b", rd_b[127:64], 64'hCCCCCCCCCCCCCCCC);
    chk("byp_same_n", rd_n[127:64], 64'h0);
    chk("byp_other", rd_b[63:0], 64'h2222222211111111);
    tick();
    idle();
    #1;
    chk("byp_next_b", rd_b[127:64], 64'hCCCCCCCCCCCCCCCC);
    chk("byp_next_n", rd_n[127:64], 64'hCCCCCCCCCCCCCCCC);

    // Asynchronous reset mid-cycle clears reg 4 before the next edge.
    wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 64'hF0F0F0F0F0F0F0F0; wr_be0 = 8'hFF;
    tick();
    idle();
    rd_addr = {5'd4, 5'd4};
    #1;
    chk("pre_rst", rd_b[63:0], 64'hF0F0F0F0F0F0F0F0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_b", rd_b[63:0], 64'h0);
    chk("async_rst_n", rd_n[127:64], 64'h0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
    chk("post_rst", rd_b[63:0], 64'h0);

    // First write after release is accepted.
    wr_en0 = 1'b1; wr_addr0 = 5'd6; wr_data0 = 64'h0123456789ABCDEF; wr_be0 = 8'hFF;
    rd_addr = {5'd6, 5'd6};
    tick();
    idle();
    #1;
    chk("first_wr", rd_n[63:0], 64'h0123456789ABCDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, 64, register width in bits; multiple of 8.
REQ-002 SHALL provide parameter ADDR_W, 5, address width; depth = 2**ADDR_W registers.
REQ-003 SHALL provide parameter NUM_RD, 2, number of independent read ports (1..4).
REQ-004 SHALL provide parameter ZERO_REG, 1, when 1 register 0 is hardwired to zero.
REQ-005 SHALL provide parameter BYPASS, 1, when 1 same-cycle write data is forwarded to reads.
REQ-006 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL provide port rdAddr  input  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL provide port rdData  output  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W].
REQ-010 SHALL provide ports wrEn0, wrEn1  input  1 each  write enables, write port 0 and 1.
REQ-011 SHALL provide ports wrAddr0, wrAddr1  input  ADDR_W each  write addresses.
REQ-012 SHALL provide ports wrData0, wrData1  input  DATA_W each  write data.
REQ-013 SHALL provide ports wrBe0, wrBe1  input  DATA_W/8 each  byte enables; bit i covers byte [8i+7:8i].

Function
REQ-014 Reads SHALL be combinational: rdData port k reflects register rdAddr port k in the same cycle, zero clock latency.
REQ-015 Writes SHALL commit on the rising clk edge when wrEnN=1 and reset=1; only bytes with wrBeN set change.
REQ-016 wrEnN=1 with wrBeN all zero SHALL leave the register unchanged.
REQ-017 Both ports to same address same cycle: per byte, wrBe1 set -> port 1 data; else wrBe0 set -> port 0 data; else old byte.
REQ-018 ZERO_REG=1: writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0 regardless of BYPASS.
REQ-019 BYPASS=1: a read of an address being written this cycle SHALL return the merged post-write value per REQ-017 byte rules.
REQ-020 BYPASS=0: a read of an address being written this cycle SHALL return the pre-write stored value; new value visible next cycle.
REQ-021 All NUM_RD read ports SHALL be independent; identical addresses on multiple ports SHALL return identical data.
REQ-022 Address range wraps naturally by ADDR_W; no out-of-range condition exists.

Reset
REQ-023 reset low SHALL clear every register to 0 immediately, without waiting for clk.
REQ-024 While reset is low, writes SHALL be ignored and all rdData SHALL read 0 (bypass suppressed).
REQ-025 A write whose edge coincides with reset low SHALL be lost; first write accepted is on the first rising edge after reset rises.

Structure
REQ-026 Package regfile_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD values and the byte-enable width constant BE_W = DATA_W/8.
REQ-027 Storage, write-merge and reset logic SHALL live in regfile_mp; one sub-module regfile_rdport (address decode, zero-reg and bypass mux) SHALL be instantiated NUM_RD times via generate.

Verification
REQ-028 Reset low 10 ns then high; read addresses 0..31 on both ports -> all rdData = 0.
REQ-029 wrEn0=1, wrAddr0=1, wrData0=64'hAAAAAAAAAAAAAAAA, wrBe0=8'hFF; next cycle read addr 1 -> 64'hAAAAAAAAAAAAAAAA; then wrBe0=8'h0F, wrData0=64'h5555555555555555 -> 64'hAAAAAAAA55555555.
REQ-030 Same cycle wrAddr0=wrAddr1=2, wrData0=64'h1111111111111111 wrBe0=8'hFF, wrData1=64'h2222222222222222 wrBe1=8'hF0 -> reg 2 = 64'h2222222211111111.
REQ-031 ZERO_REG=1: write 64'hFFFFFFFFFFFFFFFF to address 0 -> reads of address 0 return 0 same and next cycle.
REQ-032 BYPASS=1 vs BYPASS=0 builds: reg 3 = 0, write 64'hCCCCCCCCCCCCCCCC to 3 while reading 3 -> same-cycle rdData 64'hCCCCCCCCCCCCCCCC vs 0; both read 64'hCCCCCCCCCCCCCCCC next cycle.
REQ-033 Write 64'hF0F0F0F0F0F0F0F0 to reg 4, assert reset low mid-cycle between edges -> rdData for addr 4 drops to 0 before next clk edge; stays 0 after reset release.
